// File: rtl/seq_trace_buffer.sv
// rtl/seq_trace_buffer.sv - retirement trace FIFO with PC-match freeze trigger
module seq_trace_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [31:0]         pc_in,
    input  logic [31:0]         instr_in,
    input  logic [31:0]         alu_in,
    input  logic [31:0]         memdata_in,
    input  logic                cap_en,
    input  logic                trig_en,
    input  logic [31:0]         trig_pc,
    input  logic                rearm,
    input  logic                flush,
    input  logic                rec_ready,
    output logic                rec_valid,
    output logic [31:0]         rec_pc,
    output logic [31:0]         rec_instr,
    output logic [31:0]         rec_alu,
    output logic [31:0]         rec_mem,
    output logic [ADDR_W:0]     count,
    output logic                overflow,
    output logic [15:0]         drop_cnt,
    output logic                frozen
);

    typedef enum logic {
        RUN    = 1'b0,
        FROZEN = 1'b1
    } state_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    state_t              state;
    state_t              state_next;
    logic [127:0]        mem [DEPTH];
    logic [ADDR_W-1:0]   wp;
    logic [ADDR_W-1:0]   rp;
    logic [127:0]        head;

    logic                push_req;
    logic                trig_hit;
    logic                full;
    logic                pop;
    logic                push_ok;
    logic                drop;
    logic                push_go;
    logic                pop_go;

    // Capture/drain qualifiers; flush overrides both data movements
    always_comb begin
        push_req = cap_en & (state == RUN);
        trig_hit = trig_en & (pc_in == trig_pc) & push_req;
        full     = (count == FULL_CNT);
        pop      = rec_valid & rec_ready;
        push_ok  = push_req & (~full | pop);
        drop     = push_req & full & ~pop;
        push_go  = push_ok & ~flush;
        pop_go   = pop & ~flush;
    end

    // Run/frozen state register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Trigger hit freezes capture even if its own record is dropped; rearm resumes
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (trig_hit) state_next = FROZEN;
            FROZEN:  if (rearm)    state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Pointers, occupancy and drop bookkeeping
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (flush) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (push_go) wp <= wp + ADDR_W'(1);
            if (pop_go)  rp <= rp + ADDR_W'(1);
            case ({push_go, pop_go})
                2'b10:   count <= count + (ADDR_W + 1)'(1);
                2'b01:   count <= count - (ADDR_W + 1)'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // Record storage; not reset, the head outputs are gated while empty instead
    always_ff @(posedge CLK) begin
        if (push_go) mem[wp] <= {pc_in, instr_in, alu_in, memdata_in};
    end

    // First-word-fall-through head, zero while nothing is held
    always_comb begin
        rec_valid = (count != '0);
        frozen    = (state == FROZEN);
        head      = rec_valid ? mem[rp] : '0;
        rec_pc    = head[127:96];
        rec_instr = head[95:64];
        rec_alu   = head[63:32];
        rec_mem   = head[31:0];
    end

endmodule

// File: tb/tb_seq_trace_buffer.sv
// tb/tb_seq_trace_buffer.sv - self-checking bench for seq_trace_buffer
module tb_seq_trace_buffer;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              CLK = 1'b0;
    logic              RESET;
    logic [31:0]       pc_in, instr_in, alu_in, memdata_in, trig_pc;
    logic              cap_en, trig_en, rearm, flush, rec_ready;
    logic              rec_valid, overflow, frozen;
    logic [31:0]       rec_pc, rec_instr, rec_alu, rec_mem;
    logic [ADDR_W:0]   count;
    logic [15:0]       drop_cnt;

    seq_trace_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .pc_in      (pc_in),
        .instr_in   (instr_in),
        .alu_in     (alu_in),
        .memdata_in (memdata_in),
        .cap_en     (cap_en),
        .trig_en    (trig_en),
        .trig_pc    (trig_pc),
        .rearm      (rearm),
        .flush      (flush),
        .rec_ready  (rec_ready),
        .rec_valid  (rec_valid),
        .rec_pc     (rec_pc),
        .rec_instr  (rec_instr),
        .rec_alu    (rec_alu),
        .rec_mem    (rec_mem),
        .count      (count),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .frozen     (frozen)
    );

    always #5 CLK = ~CLK;

    int n_vec  = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    // Reference model: a queue of records plus the sticky status bits
    logic [127:0] q[$];
    bit           m_frozen;
    bit           m_ovf;
    int           m_drops;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_frozen = 0;
        m_ovf    = 0;
        m_drops  = 0;
    endtask

    // Apply one clock edge worth of behaviour, using the inputs held at the edge
    task automatic model_step();
        bit push_req, hit;
        push_req = cap_en && !m_frozen;
        hit      = push_req && trig_en && (pc_in == trig_pc);
        if (flush) begin
            q.delete();
            m_ovf   = 0;
            m_drops = 0;
        end else begin
            if (q.size() != 0 && rec_ready) void'(q.pop_front());
            if (push_req) begin
                if (q.size() < DEPTH) begin
                    q.push_back({pc_in, instr_in, alu_in, memdata_in});
                end else begin
                    m_ovf = 1;
                    m_drops++;
                end
            end
        end
        if (!m_frozen && hit)      m_frozen = 1;
        else if (m_frozen && rearm) m_frozen = 0;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic set_pc(input logic [31:0] pc);
        pc_in      = pc;
        instr_in   = $urandom;
        alu_in     = $urandom;
        memdata_in = $urandom;
    endtask

    // Per-cycle comparison against the model, half a period after each edge
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("rec_valid", rec_valid, q.size() != 0);
            chk("count", count, q.size());
            chk("overflow", overflow, m_ovf);
            chk("drop_cnt", drop_cnt, (m_drops > 65535) ? 65535 : m_drops);
            chk("frozen", frozen, m_frozen);
            if (q.size() != 0)
                chk("head", {rec_pc, rec_instr, rec_alu, rec_mem}, q[0]);
        end
    end

    initial begin
        RESET = 1; cap_en = 0; trig_en = 0; trig_pc = 0; rearm = 0; flush = 0;
        rec_ready = 0;
        set_pc(0);
        model_reset();
        repeat (3) @(posedge CLK);
        #1 RESET = 0;

        // Reset state
        chk("rst_valid", rec_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_frozen", frozen, 0);
        chk("rst_pc", rec_pc, 0);
        chk_en = 1;

        // Basic capture and drain
        cap_en = 1;
        for (int i = 0; i < 3; i++) begin
            set_pc(32'(i * 4));
            tick();
        end
        cap_en = 0;
        chk("basic_count", count, 3);
        chk("basic_pc0", rec_pc, 32'h0);
        rec_ready = 1;
        tick();
        chk("basic_pc1", rec_pc, 32'h4);
        tick();
        chk("basic_pc2", rec_pc, 32'h8);
        tick();
        chk("basic_empty", rec_valid, 0);
        rec_ready = 0;

        // Overflow: 18 captures, no pops
        cap_en = 1;
        for (int i = 0; i < 18; i++) begin
            set_pc(32'h100 + 32'(i * 4));
            tick();
        end
        cap_en = 0;
        chk("ovf_count", count, 16);
        chk("ovf_flag", overflow, 1);
        chk("ovf_drops", drop_cnt, 2);

        // Full with simultaneous push and pop across the pointer wrap
        cap_en = 1;
        rec_ready = 1;
        for (int i = 0; i < 5; i++) begin
            chk("pp_head", rec_pc, 32'h100 + 32'(i * 4));
            set_pc(32'h200 + 32'(i * 4));
            tick();
            chk("pp_count", count, 16);
            chk("pp_drops", drop_cnt, 2);
        end
        cap_en = 0;
        for (int k = 0; k < 16; k++) begin
            chk("drain_order", rec_pc, (k < 11) ? 32'h114 + 32'(k * 4) : 32'h200 + 32'((k - 11) * 4));
            tick();
        end
        chk("drain_empty", count, 0);

        // Empty FIFO with push and ready together
        cap_en = 1;
        set_pc(32'h300);
        tick();
        chk("empty_pp_count", count, 1);
        cap_en = 0;
        rec_ready = 0;
        flush = 1;
        tick();
        flush = 0;

        // Trigger on 0x10 while sweeping 0x0..0x20
        trig_en = 1;
        trig_pc = 32'h10;
        cap_en  = 1;
        for (int i = 0; i < 9; i++) begin
            set_pc(32'(i * 4));
            tick();
        end
        cap_en  = 0;
        trig_en = 0;
        chk("trig_count", count, 5);
        chk("trig_frozen", frozen, 1);
        chk("trig_head", rec_pc, 32'h0);
        rearm  = 1;
        cap_en = 1;
        set_pc(32'h24);
        tick();
        rearm = 0;
        chk("rearm_frozen", frozen, 0);
        chk("rearm_count", count, 5);
        set_pc(32'h28);
        tick();
        chk("resume_count", count, 6);
        cap_en = 0;

        // Flush with count 7 and overflow set
        flush = 1;
        tick();
        flush  = 0;
        cap_en = 1;
        for (int i = 0; i < 18; i++) begin
            set_pc(32'h400 + 32'(i * 4));
            tick();
        end
        cap_en    = 0;
        rec_ready = 1;
        repeat (9) tick();
        rec_ready = 0;
        chk("pre_flush_count", count, 7);
        chk("pre_flush_ovf", overflow, 1);
        flush = 1;
        tick();
        flush = 0;
        chk("flush_count", count, 0);
        chk("flush_ovf", overflow, 0);
        chk("flush_drops", drop_cnt, 0);

        // Asynchronous reset between edges while frozen with 5 records
        trig_en = 1;
        trig_pc = 32'h10;
        cap_en  = 1;
        for (int i = 0; i < 5; i++) begin
            set_pc(32'(i * 4));
            tick();
        end
        cap_en  = 0;
        trig_en = 0;
        chk("pre_rst_count", count, 5);
        chk("pre_rst_frozen", frozen, 1);
        #1 RESET = 1;
        #1;
        chk("async_count", count, 0);
        chk("async_frozen", frozen, 0);
        chk("async_valid", rec_valid, 0);
        RESET = 0;
        model_reset();

        // Randomized traffic, PCs from a small set so the trigger fires often
        for (int n = 0; n < 3000; n++) begin
            cap_en    = ($urandom_range(0, 3) != 0);
            rec_ready = ($urandom_range(0, 2) == 0);
            trig_en   = ($urandom_range(0, 3) == 0);
            trig_pc   = 32'($urandom_range(0, 7) * 4);
            rearm     = ($urandom_range(0, 7) == 0);
            flush     = ($urandom_range(0, 63) == 0);
            set_pc(32'($urandom_range(0, 7) * 4));
            tick();
        end
        cap_en = 0; rec_ready = 0; trig_en = 0; rearm = 0; flush = 0;
        tick();
        @(negedge CLK);
        chk_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
